// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C sequencer: expands register-block commands into bit-engine commands.
module i2c_master_byte_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       core_en,
  input  logic       sta,
  input  logic       sto,
  input  logic       rd,
  input  logic       wr,
  input  logic       ack,
  input  logic [7:0] txr,
  output logic [7:0] rxr,
  output logic       done,
  output logic       irxack,
  output logic       i2c_al,
  output logic [3:0] bit_cmd,
  output logic       bit_din,
  input  logic       bit_cmd_ack,
  input  logic       bit_dout,
  input  logic       bit_al
);

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [CMD_W-1:0] CMD_NOP   = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_START = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_STOP  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_WRITE = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic                din_q, din_d;
  logic                done_q, done_d;
  logic                al_q, al_d;
  logic                irxack_q, irxack_d;
  logic [DATA_W-1:0]   sr_shift;

  assign sr_shift = {sr_q[DATA_W-2:0], bit_dout};

  assign rxr     = sr_q;
  assign done    = done_q;
  assign irxack  = irxack_q;
  assign i2c_al  = al_q;
  assign bit_cmd = cmd_q;
  assign bit_din = din_q;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      cmd_q    <= CMD_NOP;
      din_q    <= 1'b0;
      done_q   <= 1'b0;
      al_q     <= 1'b0;
      irxack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      din_q    <= din_d;
      done_q   <= done_d;
      al_q     <= al_d;
      irxack_q <= irxack_d;
    end
  end

  // Next-state and next-output decode; abort conditions override everything
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    din_d    = din_q;
    done_d   = 1'b0;
    al_d     = 1'b0;
    irxack_d = irxack_q;

    if (bit_al) begin
      state_d = ST_IDLE;
      cmd_d   = CMD_NOP;
      din_d   = 1'b0;
      al_d    = 1'b1;
    end else if (!core_en) begin
      state_d = ST_IDLE;
      cmd_d   = CMD_NOP;
      din_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_d = CMD_NOP;
          din_d = 1'b0;
          // done_q blocks re-issue while the register block clears its command bits
          if (!done_q && (sta || sto || rd || wr)) begin
            if (sta) begin
              state_d = ST_START;
              cmd_d   = CMD_START;
            end else if (rd) begin
              state_d = ST_READ;
              cmd_d   = CMD_READ;
              cnt_d   = CNT_W'(7);
            end else if (wr) begin
              state_d = ST_WRITE;
              cmd_d   = CMD_WRITE;
              sr_d    = txr;
              cnt_d   = CNT_W'(7);
              din_d   = txr[DATA_W-1];
            end else begin
              state_d = ST_STOP;
              cmd_d   = CMD_STOP;
            end
          end
        end

        ST_START: begin
          if (bit_cmd_ack) begin
            if (rd) begin
              state_d = ST_READ;
              cmd_d   = CMD_READ;
              cnt_d   = CNT_W'(7);
              din_d   = 1'b0;
            end else if (wr) begin
              state_d = ST_WRITE;
              cmd_d   = CMD_WRITE;
              sr_d    = txr;
              cnt_d   = CNT_W'(7);
              din_d   = txr[DATA_W-1];
            end else if (sto) begin
              state_d = ST_STOP;
              cmd_d   = CMD_STOP;
              din_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
              cmd_d   = CMD_NOP;
              din_d   = 1'b0;
              done_d  = 1'b1;
            end
          end
        end

        ST_WRITE, ST_READ: begin
          if (bit_cmd_ack) begin
            sr_d = sr_shift;
            if (cnt_q == CNT_W'(0)) begin
              // Last data bit: the counter rests at zero instead of wrapping
              state_d = ST_ACK;
              if (state_q == ST_WRITE) begin
                cmd_d = CMD_READ;
                din_d = 1'b0;
              end else begin
                cmd_d = CMD_WRITE;
                din_d = ack;
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
              din_d = (state_q == ST_WRITE) ? sr_q[DATA_W-2] : 1'b0;
            end
          end
        end

        ST_ACK: begin
          if (bit_cmd_ack) begin
            irxack_d = bit_dout;
            din_d    = 1'b0;
            if (sto) begin
              state_d = ST_STOP;
              cmd_d   = CMD_STOP;
            end else begin
              state_d = ST_IDLE;
              cmd_d   = CMD_NOP;
              done_d  = 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (bit_cmd_ack) begin
            state_d = ST_IDLE;
            cmd_d   = CMD_NOP;
            din_d   = 1'b0;
            done_d  = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cmd_d   = CMD_NOP;
          din_d   = 1'b0;
        end
      endcase
    end
  end

endmodule
